instr_fetch_unit: RTL and testbench

//  Upstream neighbour of the single-cycle core: owns the fetch PC and issues in-order

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 58 +++++
 rtl/instr_fetch_unit.sv | 135 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants, state encoding and entry layout for the instruction fetch unit.
package fetch_pkg;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_FETCH = 2'd1,
    FS_FLUSH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO: array storage, combinational head read, flush clears all entries.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [WIDTH-1:0]           i_wdata,
  output logic [WIDTH-1:0]           o_rdata,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_count   = r_count;
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !i_flush && !o_full;
  assign w_do_pop  = i_pop && !i_flush && !o_empty;

  // Storage carries no reset so it maps onto distributed/block RAM.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch PC owner: issues in-order imem requests under a FIFO credit limit, buffers
// returned words with their PCs, and resteers on redirect by discarding in-flight responses.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          MAX_OUTST  = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic        Imem_Req_Valid,
  input  logic        Imem_Req_Ready,
  output logic [31:0] Imem_Req_Addr,
  input  logic        Imem_Rsp_Valid,
  input  logic [31:0] Imem_Rsp_Data,
  input  logic        Redirect_Valid,
  input  logic [31:0] Redirect_PC,
  output logic        Instr_Valid,
  input  logic        Instr_Ready,
  output logic [31:0] Instr,
  output logic [31:0] Instr_PC
);

  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_t  r_state;
  fetch_state_t  w_state_next;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_rsp_pc;
  logic [31:0]   r_last_pc;
  logic [31:0]   w_redirect_pc;
  logic [OW-1:0] r_outst;
  logic [OW-1:0] r_stale;
  logic [OW-1:0] w_outst_next;
  logic [OW-1:0] w_stale_next;
  logic          w_credit_ok;
  logic          w_req_fire;
  logic          w_push;
  logic          w_drop;
  logic          w_pop;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [CW-1:0] w_fifo_count;
  fetch_entry_t  w_push_entry;
  fetch_entry_t  w_head;

  assign w_redirect_pc = align_pc(Redirect_PC);

  // Every outstanding request will land in the FIFO, so reserve a slot for each.
  assign w_credit_ok = (r_outst < OW'(MAX_OUTST)) &&
                       ((32'(w_fifo_count) + 32'(r_outst)) < 32'(FIFO_DEPTH));

  assign Imem_Req_Valid = (r_state == FS_FETCH) && !Redirect_Valid && w_credit_ok;
  assign Imem_Req_Addr  = r_fetch_pc;
  assign w_req_fire     = Imem_Req_Valid && Imem_Req_Ready;

  assign w_push = Imem_Rsp_Valid && !Redirect_Valid && (r_state == FS_FETCH) && (r_stale == '0);
  assign w_drop = Imem_Rsp_Valid && !Redirect_Valid && (r_stale != '0);
  assign w_outst_next = r_outst + OW'(w_req_fire) - OW'(Imem_Rsp_Valid);
  assign w_push_entry = {Imem_Rsp_Data, r_rsp_pc};

  assign Instr_Valid = !w_fifo_empty && (r_state == FS_FETCH);
  assign w_pop       = Instr_Valid && Instr_Ready;
  assign Instr       = Instr_Valid ? w_head.instr : INSTR_NOP;
  assign Instr_PC    = Instr_Valid ? w_head.pc : r_last_pc;

  // On redirect everything still in flight becomes stale, including a same-cycle accept.
  always_comb begin
    w_stale_next = r_stale;
    if (Redirect_Valid) begin
      w_stale_next = w_outst_next;
    end else if (w_drop) begin
      w_stale_next = r_stale - OW'(1);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FS_IDLE:  w_state_next = FS_FETCH;
      FS_FETCH: if (Redirect_Valid && (w_outst_next != '0)) w_state_next = FS_FLUSH;
      FS_FLUSH: if (w_stale_next == '0) w_state_next = FS_FETCH;
      default:  w_state_next = FS_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state    <= FS_IDLE;
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_last_pc  <= RESET_PC;
      r_outst    <= '0;
      r_stale    <= '0;
    end else begin
      r_state <= w_state_next;
      r_outst <= w_outst_next;
      r_stale <= w_stale_next;
      if (Redirect_Valid) begin
        r_fetch_pc <= w_redirect_pc;
        r_rsp_pc   <= w_redirect_pc;
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + PC_STEP;
        if (w_push)     r_rsp_pc   <= r_rsp_pc + PC_STEP;
      end
      if (Instr_Valid) r_last_pc <= w_head.pc;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .i_clk   (Clock),
    .i_rst   (Reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (Redirect_Valid),
    .i_wdata (w_push_entry),
    .o_rdata (w_head),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  a_no_push_full: assert property (@(posedge Clock) disable iff (Reset)
    !(w_push && w_fifo_full));
  a_no_rsp_underflow: assert property (@(posedge Clock) disable iff (Reset)
    !(Imem_Rsp_Valid && (r_outst == '0)));
  a_no_outst_overflow: assert property (@(posedge Clock) disable iff (Reset)
    !(w_req_fire && !Imem_Rsp_Valid && (r_outst == OW'(MAX_OUTST))));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: in-order memory model with programmable latency,
// per-scenario tasks with hand-computed expected PCs and handshake timing.
module tb_instr_fetch_unit;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Imem_Req_Valid;
  logic        Imem_Req_Ready = 1'b1;
  logic [31:0] Imem_Req_Addr;
  logic        Imem_Rsp_Valid = 1'b0;
  logic [31:0] Imem_Rsp_Data = 32'h0;
  logic        Redirect_Valid = 1'b0;
  logic [31:0] Redirect_PC = 32'h0;
  logic        Instr_Valid;
  logic        Instr_Ready = 1'b1;
  logic [31:0] Instr;
  logic [31:0] Instr_PC;

  typedef struct {
    logic [31:0] addr;
    int          cyc;
  } rec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int          cyc;
  } obs_t;

  rec_t mq[$];
  rec_t acc[$];
  obs_t obs[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   lat = 1;

  instr_fetch_unit dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .Imem_Req_Valid (Imem_Req_Valid),
    .Imem_Req_Ready (Imem_Req_Ready),
    .Imem_Req_Addr  (Imem_Req_Addr),
    .Imem_Rsp_Valid (Imem_Rsp_Valid),
    .Imem_Rsp_Data  (Imem_Rsp_Data),
    .Redirect_Valid (Redirect_Valid),
    .Redirect_PC    (Redirect_PC),
    .Instr_Valid    (Instr_Valid),
    .Instr_Ready    (Instr_Ready),
    .Instr          (Instr),
    .Instr_PC       (Instr_PC)
  );

  initial forever #5 Clock = ~Clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory: accept sampled mid-cycle, response delivered lat cycles later, in order.
  initial begin
    rec_t r;
    forever begin
      @(posedge Clock);
      cyc++;
      #1;
      if (!Reset && mq.size() > 0 && mq[0].cyc <= cyc) begin
        Imem_Rsp_Valid = 1'b1;
        Imem_Rsp_Data  = mem_word(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        Imem_Rsp_Valid = 1'b0;
        Imem_Rsp_Data  = 32'h0;
      end
      @(negedge Clock);
      if (!Reset && Imem_Req_Valid && Imem_Req_Ready) begin
        r.addr = Imem_Req_Addr;
        r.cyc  = cyc + lat;
        mq.push_back(r);
        r.cyc  = cyc;
        acc.push_back(r);
        $display("req   addr=%h cyc=%0d", Imem_Req_Addr, cyc);
      end
    end
  end

  initial begin
    obs_t o;
    forever begin
      @(negedge Clock);
      if (!Reset && Instr_Valid && Instr_Ready) begin
        o.pc    = Instr_PC;
        o.instr = Instr;
        o.cyc   = cyc;
        obs.push_back(o);
        $display("instr pc=%h word=%h cyc=%0d", Instr_PC, Instr, cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time expired, required completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input int l, input logic rr, input logic ir);
    @(posedge Clock); #1;
    Reset = 1'b1; Redirect_Valid = 1'b0; Redirect_PC = 32'h0;
    lat = l; Imem_Req_Ready = rr; Instr_Ready = ir;
    mq.delete(); acc.delete(); obs.delete();
    repeat (2) @(posedge Clock);
    #1;
    mq.delete(); acc.delete(); obs.delete();
    Reset = 1'b0;
  endtask

  task automatic wait_obs(input int n, input int budget, output bit ok);
    for (int k = 0; k < budget && obs.size() < n; k++) @(posedge Clock);
    ok = (obs.size() >= n);
  endtask

  task automatic test_reset;
    @(negedge Clock); @(negedge Clock);
    n_cmp++; if (Imem_Req_Valid !== 1'b0) begin n_bad++; $display("FAIL reset_req_valid: got %b want 0", Imem_Req_Valid); end
    n_cmp++; if (Imem_Req_Addr !== 32'h0) begin n_bad++; $display("FAIL reset_req_addr: got %h want 00000000", Imem_Req_Addr); end
    n_cmp++; if (Instr_Valid !== 1'b0) begin n_bad++; $display("FAIL reset_instr_valid: got %b want 0", Instr_Valid); end
    n_cmp++; if (Instr !== 32'h0000_0013) begin n_bad++; $display("FAIL reset_instr: got %h want 00000013", Instr); end
    n_cmp++; if (Instr_PC !== 32'h0) begin n_bad++; $display("FAIL reset_instr_pc: got %h want 00000000", Instr_PC); end
  endtask

  task automatic test_stream;
    bit ok;
    logic [31:0] exp_pc;
    do_reset(1, 1'b1, 1'b1);
    wait_obs(4, 20, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL stream_count: got %0d instrs want >=4", obs.size()); end
    if (ok && acc.size() > 0) begin
      for (int i = 0; i < 4; i++) begin
        exp_pc = 32'(4 * i);
        n_cmp++; if (obs[i].pc !== exp_pc) begin n_bad++; $display("FAIL stream_pc%0d: got %h want %h", i, obs[i].pc, exp_pc); end
        n_cmp++; if (obs[i].instr !== mem_word(exp_pc)) begin n_bad++; $display("FAIL stream_word%0d: got %h want %h", i, obs[i].instr, mem_word(exp_pc)); end
        n_cmp++; if (obs[i].cyc !== obs[0].cyc + i) begin n_bad++; $display("FAIL stream_cycle%0d: got %0d want %0d", i, obs[i].cyc, obs[0].cyc + i); end
      end
      n_cmp++; if (obs[0].cyc - acc[0].cyc !== 2) begin n_bad++; $display("FAIL stream_latency: got %0d want 2", obs[0].cyc - acc[0].cyc); end
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    do_reset(1, 1'b1, 1'b0);
    repeat (12) @(posedge Clock);
    @(negedge Clock);
    n_cmp++; if (acc.size() !== 4) begin n_bad++; $display("FAIL bp_req_count: got %0d want 4", acc.size()); end
    for (int i = 0; i < 4 && i < acc.size(); i++) begin
      n_cmp++; if (acc[i].addr !== 32'(4 * i)) begin n_bad++; $display("FAIL bp_req_addr%0d: got %h want %h", i, acc[i].addr, 32'(4 * i)); end
    end
    n_cmp++; if (Imem_Req_Valid !== 1'b0) begin n_bad++; $display("FAIL bp_req_valid: got %b want 0", Imem_Req_Valid); end
    n_cmp++; if (Instr_Valid !== 1'b1) begin n_bad++; $display("FAIL bp_instr_valid: got %b want 1", Instr_Valid); end
    n_cmp++; if (Instr_PC !== 32'h0) begin n_bad++; $display("FAIL bp_head_pc: got %h want 00000000", Instr_PC); end
    n_cmp++; if (Instr !== 32'hC0DE_0000) begin n_bad++; $display("FAIL bp_head_word: got %h want c0de0000", Instr); end
    @(posedge Clock); #1;
    Instr_Ready = 1'b1;
    for (int k = 0; k < 10 && acc.size() < 5; k++) @(posedge Clock);
    n_cmp++; if (acc.size() < 5) begin n_bad++; $display("FAIL bp_resume: got %0d reqs want 5", acc.size()); end
    else begin
      n_cmp++; if (acc[4].addr !== 32'h10) begin n_bad++; $display("FAIL bp_resume_addr: got %h want 00000010", acc[4].addr); end
    end
    wait_obs(5, 20, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_obs_count: got %0d want >=5", obs.size()); end
    else begin
      n_cmp++; if (obs[4].pc !== 32'h10) begin n_bad++; $display("FAIL bp_obs_pc4: got %h want 00000010", obs[4].pc); end
    end
  endtask

  task automatic test_redirect_flush;
    bit ok;
    int k;
    do_reset(3, 1'b1, 1'b1);
    k = 0;
    while (acc.size() < 2 && k < 20) begin @(posedge Clock); #1; k++; end
    n_cmp++; if (acc.size() !== 2) begin n_bad++; $display("FAIL flush_pre_reqs: got %0d want 2", acc.size()); end
    Redirect_Valid = 1'b1; Redirect_PC = 32'h100;
    @(negedge Clock);
    n_cmp++; if (Imem_Req_Valid !== 1'b0) begin n_bad++; $display("FAIL flush_redirect_gate: got %b want 0", Imem_Req_Valid); end
    @(posedge Clock); #1;
    Redirect_Valid = 1'b0;
    @(negedge Clock);
    n_cmp++; if (Imem_Req_Valid !== 1'b0) begin n_bad++; $display("FAIL flush_hold1: got %b want 0", Imem_Req_Valid); end
    @(negedge Clock);
    n_cmp++; if (Imem_Req_Valid !== 1'b0) begin n_bad++; $display("FAIL flush_hold2: got %b want 0", Imem_Req_Valid); end
    @(negedge Clock);
    n_cmp++; if (Imem_Req_Valid !== 1'b1) begin n_bad++; $display("FAIL flush_resume_valid: got %b want 1", Imem_Req_Valid); end
    n_cmp++; if (Imem_Req_Addr !== 32'h100) begin n_bad++; $display("FAIL flush_resume_addr: got %h want 00000100", Imem_Req_Addr); end
    wait_obs(1, 20, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL flush_obs_count: got %0d want >=1", obs.size()); end
    else begin
      n_cmp++; if (obs[0].pc !== 32'h100) begin n_bad++; $display("FAIL flush_first_pc: got %h want 00000100", obs[0].pc); end
      n_cmp++; if (obs[0].instr !== 32'hC0DE_0100) begin n_bad++; $display("FAIL flush_first_word: got %h want c0de0100", obs[0].instr); end
    end
  endtask

  task automatic test_redirect_collide;
    bit ok;
    int k;
    do_reset(2, 1'b1, 1'b1);
    k = 0;
    while (acc.size() < 4 && k < 20) begin @(posedge Clock); #1; k++; end
    n_cmp++; if (acc.size() !== 4) begin n_bad++; $display("FAIL coll_pre_reqs: got %0d want 4", acc.size()); end
    Redirect_Valid = 1'b1; Redirect_PC = 32'h200;
    @(negedge Clock);
    n_cmp++; if (Imem_Req_Valid !== 1'b0) begin n_bad++; $display("FAIL coll_redirect_gate: got %b want 0", Imem_Req_Valid); end
    n_cmp++; if (Instr_PC !== 32'h4) begin n_bad++; $display("FAIL coll_head_pc: got %h want 00000004", Instr_PC); end
    @(posedge Clock); #1;
    Redirect_Valid = 1'b0;
    @(negedge Clock);
    n_cmp++; if (Instr_Valid !== 1'b0) begin n_bad++; $display("FAIL coll_flushed: got %b want 0", Instr_Valid); end
    n_cmp++; if (Imem_Req_Valid !== 1'b0) begin n_bad++; $display("FAIL coll_stale_hold: got %b want 0", Imem_Req_Valid); end
    @(negedge Clock);
    n_cmp++; if (Imem_Req_Valid !== 1'b1) begin n_bad++; $display("FAIL coll_resume_valid: got %b want 1", Imem_Req_Valid); end
    n_cmp++; if (Imem_Req_Addr !== 32'h200) begin n_bad++; $display("FAIL coll_resume_addr: got %h want 00000200", Imem_Req_Addr); end
    wait_obs(4, 30, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL coll_obs_count: got %0d want >=4", obs.size()); end
    else begin
      n_cmp++; if (obs[1].pc !== 32'h4) begin n_bad++; $display("FAIL coll_pc1: got %h want 00000004", obs[1].pc); end
      n_cmp++; if (obs[2].pc !== 32'h200) begin n_bad++; $display("FAIL coll_pc2: got %h want 00000200", obs[2].pc); end
      n_cmp++; if (obs[2].instr !== 32'hC0DE_0200) begin n_bad++; $display("FAIL coll_word2: got %h want c0de0200", obs[2].instr); end
      n_cmp++; if (obs[3].pc !== 32'h204) begin n_bad++; $display("FAIL coll_pc3: got %h want 00000204", obs[3].pc); end
    end
  endtask

  task automatic test_wrap;
    bit ok;
    do_reset(1, 1'b1, 1'b1);
    @(posedge Clock); #1;
    Redirect_Valid = 1'b1; Redirect_PC = 32'hFFFF_FFFA;
    @(posedge Clock); #1;
    Redirect_Valid = 1'b0;
    wait_obs(3, 20, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL wrap_obs_count: got %0d want >=3", obs.size()); end
    else begin
      n_cmp++; if (acc[0].addr !== 32'hFFFF_FFF8) begin n_bad++; $display("FAIL wrap_req0: got %h want fffffff8", acc[0].addr); end
      n_cmp++; if (obs[0].pc !== 32'hFFFF_FFF8) begin n_bad++; $display("FAIL wrap_pc0: got %h want fffffff8", obs[0].pc); end
      n_cmp++; if (obs[1].pc !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_pc1: got %h want fffffffc", obs[1].pc); end
      n_cmp++; if (obs[2].pc !== 32'h0) begin n_bad++; $display("FAIL wrap_pc2: got %h want 00000000", obs[2].pc); end
      n_cmp++; if (obs[2].instr !== 32'hC0DE_0000) begin n_bad++; $display("FAIL wrap_word2: got %h want c0de0000", obs[2].instr); end
    end
  endtask

  task automatic test_reset_midstream;
    bit ok;
    do_reset(1, 1'b1, 1'b0);
    repeat (10) @(posedge Clock);
    @(negedge Clock);
    n_cmp++; if (Instr_Valid !== 1'b1) begin n_bad++; $display("FAIL mid_full_valid: got %b want 1", Instr_Valid); end
    n_cmp++; if (Imem_Req_Valid !== 1'b0) begin n_bad++; $display("FAIL mid_full_noreq: got %b want 0", Imem_Req_Valid); end
    @(posedge Clock); #1;
    Reset = 1'b1;
    #1;
    n_cmp++; if (Imem_Req_Valid !== 1'b0) begin n_bad++; $display("FAIL mid_req_valid: got %b want 0", Imem_Req_Valid); end
    n_cmp++; if (Imem_Req_Addr !== 32'h0) begin n_bad++; $display("FAIL mid_req_addr: got %h want 00000000", Imem_Req_Addr); end
    n_cmp++; if (Instr_Valid !== 1'b0) begin n_bad++; $display("FAIL mid_instr_valid: got %b want 0", Instr_Valid); end
    n_cmp++; if (Instr !== 32'h0000_0013) begin n_bad++; $display("FAIL mid_instr: got %h want 00000013", Instr); end
    n_cmp++; if (Instr_PC !== 32'h0) begin n_bad++; $display("FAIL mid_instr_pc: got %h want 00000000", Instr_PC); end
    repeat (2) @(posedge Clock);
    #1;
    mq.delete(); acc.delete(); obs.delete();
    Instr_Ready = 1'b1;
    Reset = 1'b0;
    wait_obs(1, 20, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL mid_restart_count: got %0d want >=1", obs.size()); end
    else begin
      n_cmp++; if (acc[0].addr !== 32'h0) begin n_bad++; $display("FAIL mid_restart_req: got %h want 00000000", acc[0].addr); end
      n_cmp++; if (obs[0].pc !== 32'h0) begin n_bad++; $display("FAIL mid_restart_pc: got %h want 00000000", obs[0].pc); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_redirect_collide();
    test_wrap();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
